// File: rtl/bus_drive_ctrl_if.sv
// Handshake and driver-side signals of the bus drive sequencer.
// master: upstream/arbiter side; slave: the sequencer itself.
interface bus_drive_ctrl_if #(
    parameter int DW = 4
);
    logic          req_valid;
    logic [DW-1:0] req_data;
    logic          req_ready;
    logic          gnt;
    logic          bus_req;
    logic [DW-1:0] drv_data;
    logic          drv_en_n;
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_data, gnt,
        input  req_ready, bus_req, drv_data, drv_en_n, done, err
    );

    modport slave (
        input  req_valid, req_data, gnt,
        output req_ready, bus_req, drv_data, drv_en_n, done, err
    );
endinterface

// File: rtl/bus_drive_ctrl.sv
// Sequencer for the shared tri-state bus driver: accept word, request bus, drive for HOLD cycles.
// BUS_DRV_TURNAROUND_EN adds a one-cycle TURN state (guaranteed idle bus) after each drive window.
//
// state | meaning
// IDLE  | ready for a new word; bus released
// REQ   | word latched, bus_req high, waiting for gnt (bounded by TIMEOUT)
// DRIVE | drv_en_n low, latched word on drv_data for HOLD cycles
// TURN  | one bus-idle cycle after a drive window (macro builds only)
module bus_drive_ctrl #(
    parameter int DW      = 4,
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    bus_drive_ctrl_if.slave bus
);
    localparam int CMAX = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

`ifdef BUS_DRV_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, REQ, DRIVE, TURN} state_t;
    localparam state_t DRIVE_EXIT = TURN;
`else
    typedef enum logic [1:0] {IDLE, REQ, DRIVE} state_t;
    localparam state_t DRIVE_EXIT = IDLE;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // One counter serves as wait counter in REQ and hold counter in DRIVE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    data_d  = bus.req_data;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.gnt) begin
                    cnt_d   = CW'(HOLD - 1);
                    state_d = DRIVE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRIVE: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                // Losing grant takes priority so done and err never coincide.
                if (!bus.gnt) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DRIVE_EXIT;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = DRIVE_EXIT;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.bus_req   = (state_q == REQ) || (state_q == DRIVE);
    assign bus.drv_en_n  = (state_q != DRIVE);
    assign bus.drv_data  = data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_drive_ctrl.sv
// Directed self-checking bench for bus_drive_ctrl (DW=4, HOLD=2, TIMEOUT=15).
module tb_bus_drive_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

`ifdef BUS_DRV_TURNAROUND_EN
    localparam int EXP_GAP = 3;
`else
    localparam int EXP_GAP = 2;
`endif

    bus_drive_ctrl_if #(.DW(4)) bus ();

    bus_drive_ctrl #(.DW(4), .HOLD(2), .TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_req, n_err, n_drv, n_done, err_idx;
        int n_acc, w1s, w1e, w2s, w2e;
        logic prev_ready;
        logic [7:0] en_s [0:13];
        logic [7:0] d_s  [0:13];

        bus.req_valid = 1'b0;
        bus.req_data  = 4'h0;
        bus.gnt       = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_bus_req", bus.bus_req, 0);
        chk("rst_en_n", bus.drv_en_n, 1);
        chk("rst_data", bus.drv_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);

        // basic transfer, gnt tied high
        bus.gnt = 1'b1; bus.req_valid = 1'b1; bus.req_data = 4'hA;
        step(); bus.req_valid = 1'b0;
        chk("basic_c1_bus_req", bus.bus_req, 1);
        chk("basic_c1_ready", bus.req_ready, 0);
        chk("basic_c1_en_n", bus.drv_en_n, 1);
        step();
        chk("basic_c2_en_n", bus.drv_en_n, 0);
        chk("basic_c2_data", bus.drv_data, 4'hA);
        step();
        chk("basic_c3_en_n", bus.drv_en_n, 0);
        chk("basic_c3_done", bus.done, 0);
        step();
        chk("basic_c4_done", bus.done, 1);
        chk("basic_c4_err", bus.err, 0);
        chk("basic_c4_en_n", bus.drv_en_n, 1);
        chk("basic_c4_bus_req", bus.bus_req, 0);
        step();
        chk("basic_c5_ready", bus.req_ready, 1);
        chk("basic_c5_done", bus.done, 0);

        // delayed grant: 5 REQ cycles, grant arrives in the 5th
        bus.gnt = 1'b0; bus.req_valid = 1'b1; bus.req_data = 4'h6;
        step(); bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("dly_req_bus_req", bus.bus_req, 1);
            chk("dly_req_en_n", bus.drv_en_n, 1);
            if (i == 4) bus.gnt = 1'b1;
            step();
        end
        chk("dly_d1_en_n", bus.drv_en_n, 0);
        chk("dly_d1_data", bus.drv_data, 4'h6);
        step();
        chk("dly_d2_en_n", bus.drv_en_n, 0);
        step();
        chk("dly_done", bus.done, 1);
        chk("dly_en_n_off", bus.drv_en_n, 1);
        step(); step();

        // timeout with gnt held low
        bus.gnt = 1'b0; bus.req_valid = 1'b1; bus.req_data = 4'h9;
        step(); bus.req_valid = 1'b0;
        n_req = 0; n_err = 0; n_drv = 0; n_done = 0; err_idx = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.bus_req) n_req++;
            if (bus.err) begin n_err++; err_idx = i; end
            if (!bus.drv_en_n) n_drv++;
            if (bus.done) n_done++;
            step();
        end
        chk("to_bus_req_cycles", 8'(n_req), 15);
        chk("to_err_count", 8'(n_err), 1);
        chk("to_err_cycle", 8'(err_idx), 15);
        chk("to_drive_cycles", 8'(n_drv), 0);
        chk("to_done_count", 8'(n_done), 0);
        chk("to_ready", bus.req_ready, 1);

        // grant loss in first DRIVE cycle
        bus.gnt = 1'b1; bus.req_valid = 1'b1; bus.req_data = 4'hB;
        step(); bus.req_valid = 1'b0;
        step();
        chk("gl_d1_en_n", bus.drv_en_n, 0);
        bus.gnt = 1'b0;
        step();
        chk("gl_en_n", bus.drv_en_n, 1);
        chk("gl_err", bus.err, 1);
        chk("gl_done", bus.done, 0);
        step();
        chk("gl_next_err", bus.err, 0);
        chk("gl_next_done", bus.done, 0);
        chk("gl_next_ready", bus.req_ready, 1);

        // asynchronous reset mid-DRIVE
        bus.gnt = 1'b1; bus.req_valid = 1'b1; bus.req_data = 4'hC;
        step(); bus.req_valid = 1'b0;
        step();
        chk("ar_pre_en_n", bus.drv_en_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_en_n", bus.drv_en_n, 1);
        chk("ar_bus_req", bus.bus_req, 0);
        step(); rst = 1'b0;
        step();
        chk("ar_ready", bus.req_ready, 1);
        chk("ar_data", bus.drv_data, 0);
        chk("ar_bus_req_after", bus.bus_req, 0);

        // back-to-back with req_valid held high
        bus.gnt = 1'b1; bus.req_valid = 1'b1; bus.req_data = 4'h3;
        prev_ready = 1'b1; n_acc = 0; n_done = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            en_s[i] = {7'd0, bus.drv_en_n};
            d_s[i]  = {4'd0, bus.drv_data};
            if (bus.done) n_done++;
            if (!bus.req_ready && prev_ready) begin
                n_acc++;
                if (n_acc == 1) bus.req_data = 4'h5;
                if (n_acc == 2) bus.req_valid = 1'b0;
            end
            prev_ready = bus.req_ready;
        end
        w1s = -1; w1e = -1; w2s = -1; w2e = -1;
        for (int i = 0; i < 14; i++) begin
            if (en_s[i] == 0 && (i == 0 || en_s[i-1] == 1)) begin
                if (w1s < 0) w1s = i; else if (w2s < 0) w2s = i;
            end
            if (en_s[i] == 0 && (i == 13 || en_s[i+1] == 1)) begin
                if (w1e < 0) w1e = i; else if (w2e < 0) w2e = i;
            end
        end
        chk("b2b_w1_start", 8'(w1s), 1);
        chk("b2b_w1_len", 8'(w1e - w1s + 1), 2);
        chk("b2b_w2_len", 8'(w2e - w2s + 1), 2);
        chk("b2b_gap", 8'(w2s - w1e - 1), 8'(EXP_GAP));
        chk("b2b_w1_data", (w1s >= 0) ? d_s[w1s] : 8'hFF, 8'h3);
        chk("b2b_w2_data", (w2s >= 0) ? d_s[w2s] : 8'hFF, 8'h5);
        chk("b2b_done_count", 8'(n_done), 2);
        chk("b2b_final_ready", bus.req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
